mod_demod_sched: RTL and testbench

Sequencer and arbiter that shares one combinational mod_demod_top datapath (21-bit mod_in -> 21-bit demod_out) between NUM_REQ requesters. It accepts one word at a time through a valid/ready handshake and drives it onto the datapath. It waits a fixed settle time, captures demod_out, and returns the result with requester ID and a mismatch flag. It sits between the link-layer word sources and the mod/demod datapath. It also keeps a running error count for BER bring-up.

---
 rtl/mod_demod_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mod_demod_sched.sv | 165 ++++++++++++++++
 tb/tb_mod_demod_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_demod_pkg.sv
// Shared types and constants for the mod/demod scheduler.
//   WIDTH_C : native codeword width of the mod/demod datapath
//   word_t  : one codeword
//   state_e : scheduler FSM states
package mod_demod_pkg;

   localparam int unsigned WIDTH_C = 21;

   typedef logic [WIDTH_C-1:0] word_t;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSettle  = 2'd1,
      StRespond = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted valid found searching upward from
// ptr_i, wrapping around.
// Ports:
//   valid_i : per-requester request
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot grant, all-zero when no request is valid
//   idx_o   : index of the granted requester (0 when none)
module rr_arbiter #(
   parameter int unsigned  NUM_REQ = 2,
   localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IdW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IdW-1:0]     idx_o
);

   logic           found;
   logic [IdW-1:0] j;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = IdW'((32'(ptr_i) + k) % NUM_REQ);
         if (!found && valid_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = j;
         end
      end
   end

endmodule

// File: rtl/mod_demod_sched.sv
// Shares one combinational mod/demod datapath between NUM_REQ requesters. A word is
// accepted over valid/ready, driven onto the datapath, left to settle, then the datapath
// output is captured and returned with the requester ID and a mismatch flag. A saturating
// mismatch counter supports BER bring-up.
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : synchronous active-low reset
//   req_valid_i    : per-requester word valid
//   req_data_i     : packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o    : one-hot grant/accept (IDLE only)
//   dp_mod_in_o    : registered word to datapath
//   dp_demod_out_i : datapath result
//   resp_valid_o   : result available, held until resp_ready_i
//   resp_ready_i   : consumer accepts result
//   resp_id_o      : requester that issued the word
//   resp_data_o    : captured datapath result
//   resp_err_o     : captured result differs from issued word
//   err_count_o    : saturating mismatch count
//   busy_o         : FSM not idle
module mod_demod_sched
   import mod_demod_pkg::*;
#(
   parameter int unsigned  WIDTH         = WIDTH_C,
   parameter int unsigned  NUM_REQ       = 2,
   parameter int unsigned  SETTLE_CYCLES = 2,
   parameter int unsigned  CNT_W         = 16,
   localparam int unsigned IdW           = $clog2(NUM_REQ)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic [WIDTH-1:0]           dp_mod_in_o,
   input  logic [WIDTH-1:0]           dp_demod_out_i,
   output logic                       resp_valid_o,
   input  logic                       resp_ready_i,
   output logic [IdW-1:0]             resp_id_o,
   output logic [WIDTH-1:0]           resp_data_o,
   output logic                       resp_err_o,
   output logic [CNT_W-1:0]           err_count_o,
   output logic                       busy_o
);

   // Counter holds values 0..SETTLE_CYCLES-1.
   localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_e             state_q, state_d;
   logic [SetW-1:0]    cnt_q, cnt_d;
   logic [IdW-1:0]     rr_q, rr_d;
   logic [IdW-1:0]     id_q, id_d;
   logic [WIDTH-1:0]   mod_q, mod_d;
   logic [WIDTH-1:0]   rdata_q, rdata_d;
   logic               rvalid_q, rvalid_d;
   logic               rerr_q, rerr_d;
   logic [CNT_W-1:0]   err_q, err_d;

   logic [NUM_REQ-1:0] grant;
   logic [IdW-1:0]     grant_idx;
   logic               accept;
   logic               settle_done;
   logic               resp_fire;
   logic               mismatch;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .valid_i (req_valid_i),
      .ptr_i   (rr_q),
      .grant_o (grant),
      .idx_o   (grant_idx)
   );

   // Grant is non-zero exactly when some request is valid.
   assign accept      = (state_q == StIdle) && (|req_valid_i);
   assign settle_done = (state_q == StSettle) && (cnt_q == '0);
   assign resp_fire   = (state_q == StRespond) && resp_ready_i;
   // mod_q still holds the issued word while settling.
   assign mismatch    = (dp_demod_out_i != mod_q);

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (accept)      state_d = StSettle;
         StSettle:  if (cnt_q == '0) state_d = StRespond;
         StRespond: if (resp_ready_i) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_ready_o = (state_q == StIdle) ? grant : '0;
      busy_o      = (state_q != StIdle);
   end

   // Datapath / capture next-state
   always_comb begin
      mod_d    = mod_q;
      id_d     = id_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      err_d    = err_q;
      if (accept) begin
         mod_d = req_data_i[grant_idx*WIDTH +: WIDTH];
         id_d  = grant_idx;
         rr_d  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
         cnt_d = SetW'(SETTLE_CYCLES - 1);
      end else if (settle_done) begin
         rvalid_d = 1'b1;
         rdata_d  = dp_demod_out_i;
         rerr_d   = mismatch;
         if (mismatch && !(&err_q)) begin
            err_d = err_q + 1'b1;
         end
      end else if (state_q == StSettle) begin
         cnt_d = cnt_q - 1'b1;
      end else if (resp_fire) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mod_q    <= '0;
         id_q     <= '0;
         rr_q     <= '0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         mod_q    <= mod_d;
         id_q     <= id_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
         err_q    <= err_d;
      end
   end

   assign dp_mod_in_o  = mod_q;
   assign resp_valid_o = rvalid_q;
   assign resp_id_o    = id_q;
   assign resp_data_o  = rdata_q;
   assign resp_err_o   = rerr_q;
   assign err_count_o  = err_q;

endmodule

// File: tb/tb_mod_demod_sched.sv
// Bench for mod_demod_sched: loopback / corrupting datapath models, reference model of
// round-robin order, latency and saturating error count.
module tb_mod_demod_sched;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [41:0] req_data;
   logic [1:0]  req_ready;
   logic [20:0] dp_mod, dp_demod, corrupt;
   logic        resp_valid, resp_ready;
   logic [0:0]  resp_id;
   logic [20:0] resp_data;
   logic        resp_err;
   logic [15:0] err_count;
   logic        busy;

   // Second instance with a 2-bit counter and a datapath that always flips bit 0.
   logic [1:0]  s_valid, s_ready;
   logic [41:0] s_data;
   logic [20:0] s_mod, s_demod;
   logic        s_resp_valid, s_err, s_busy;
   logic        s_resp_ready = 1'b1;
   logic [0:0]  s_id;
   logic [20:0] s_rdata;
   logic [1:0]  s_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int m_rr  = 0;
   int m_err = 0;

   assign dp_demod = dp_mod ^ corrupt;
   assign s_demod  = s_mod ^ 21'h000001;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mod_demod_sched u_dut (
      .clk_i (clk), .rst_ni (rst_n), .req_valid_i (req_valid), .req_data_i (req_data),
      .req_ready_o (req_ready), .dp_mod_in_o (dp_mod), .dp_demod_out_i (dp_demod),
      .resp_valid_o (resp_valid), .resp_ready_i (resp_ready), .resp_id_o (resp_id),
      .resp_data_o (resp_data), .resp_err_o (resp_err), .err_count_o (err_count),
      .busy_o (busy)
   );

   mod_demod_sched #(.CNT_W (2)) u_sat (
      .clk_i (clk), .rst_ni (rst_n), .req_valid_i (s_valid), .req_data_i (s_data),
      .req_ready_o (s_ready), .dp_mod_in_o (s_mod), .dp_demod_out_i (s_demod),
      .resp_valid_o (s_resp_valid), .resp_ready_i (s_resp_ready), .resp_id_o (s_id),
      .resp_data_o (s_rdata), .resp_err_o (s_err), .err_count_o (s_cnt), .busy_o (s_busy)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference rule: first valid requester at or above the pointer, with wrap.
   function automatic int exp_grant(input logic [1:0] vm);
      for (int k = 0; k < 2; k++) begin
         if (vm[(m_rr + k) % 2]) return (m_rr + k) % 2;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 1'b0;
      s_valid    = 2'b00;
      tick();
      tick();
      rst_n = 1'b1;
      m_rr  = 0;
      m_err = 0;
   endtask

   // Runs one transaction and reports what was observed; callers do the comparing.
   task automatic txn(input logic [1:0] vm, input logic [20:0] d0, input logic [20:0] d1,
                      input int hold, input bit keep_valid,
                      output int g, output int acc_cyc, output logic [20:0] mod_seen,
                      output int lat, output logic [20:0] rdata, output logic [0:0] rid,
                      output logic rerr, output bit held_ok, output logic post_valid,
                      output logic post_busy);
      int n;
      req_data   = {d1, d0};
      req_valid  = vm;
      resp_ready = (hold == 0);
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         tick();
         n++;
      end
      g = -1;
      if (req_ready == 2'b01) g = 0;
      else if (req_ready == 2'b10) g = 1;
      tick();
      acc_cyc = cyc;
      if (!keep_valid) req_valid = 2'b00;
      mod_seen = dp_mod;
      lat = 0;
      while (!resp_valid && lat < 20) begin
         tick();
         lat++;
      end
      rdata   = resp_data;
      rid     = resp_id;
      rerr    = resp_err;
      held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (resp_valid !== 1'b1 || resp_data !== rdata || resp_id !== rid ||
             resp_err !== rerr || req_ready !== 2'b00 || busy !== 1'b1) held_ok = 1'b0;
      end
      resp_ready = 1'b1;
      tick();
      post_valid = resp_valid;
      post_busy  = busy;
   endtask

   task automatic test_reset();
      corrupt = '0;
      req_data = '0;
      s_data = '0;
      do_reset();
      rst_n = 1'b0;
      tick();
      total++; if (dp_mod !== 21'h0) begin bad++; $display("FAIL rst_mod got %h want 0", dp_mod); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", resp_valid); end
      total++; if (resp_id !== 1'b0) begin bad++; $display("FAIL rst_id got %0d want 0", resp_id); end
      total++; if (resp_data !== 21'h0) begin bad++; $display("FAIL rst_data got %h want 0", resp_data); end
      total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", resp_err); end
      total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rst_cnt got %0d want 0", err_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready_idle got %b want 00", req_ready); end
      req_valid = 2'b11;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_ready_ptr got %b want 01", req_ready); end
      req_valid = 2'b00;
      rst_n = 1'b1;
   endtask

   task automatic test_loopback();
      int g, ac, lat;
      logic [20:0] ms, rd;
      logic [0:0] ri;
      logic re, pv, pb;
      bit ho;
      corrupt = '0;
      txn(2'b01, 21'h133333, 21'h0, 0, 1'b0, g, ac, ms, lat, rd, ri, re, ho, pv, pb);
      total++; if (g !== 0) begin bad++; $display("FAIL lb_grant got %0d want 0", g); end
      total++; if (ms !== 21'h133333) begin bad++; $display("FAIL lb_mod got %h want 133333", ms); end
      total++; if (lat !== S) begin bad++; $display("FAIL lb_latency got %0d want %0d", lat, S); end
      total++; if (rd !== 21'h133333) begin bad++; $display("FAIL lb_data got %h want 133333", rd); end
      total++; if (ri !== 1'b0 || re !== 1'b0) begin bad++; $display("FAIL lb_id_err got %0d/%b want 0/0", ri, re); end
      total++; if (err_count !== 16'd0) begin bad++; $display("FAIL lb_cnt got %0d want 0", err_count); end
      total++; if (pv !== 1'b0 || pb !== 1'b0) begin bad++; $display("FAIL lb_post got v%b b%b want v0 b0", pv, pb); end
      m_rr = 1;
   endtask

   task automatic test_back_to_back();
      int g, ac, lat, prev_ac;
      logic [20:0] ms, rd, want;
      logic [0:0] ri;
      logic re, pv, pb;
      bit ho;
      do_reset();
      corrupt = '0;
      prev_ac = 0;
      for (int t = 0; t < 4; t++) begin
         int eg;
         eg = exp_grant(2'b11);
         want = (eg == 0) ? 21'h0CCCCC : 21'h1FF800;
         txn(2'b11, 21'h0CCCCC, 21'h1FF800, 0, 1'b1, g, ac, ms, lat, rd, ri, re, ho, pv, pb);
         total++; if (g !== t % 2 || g !== eg) begin bad++; $display("FAIL b2b_grant%0d got %0d want %0d", t, g, t % 2); end
         total++; if (int'(ri) !== eg || rd !== want) begin bad++; $display("FAIL b2b_resp%0d got id%0d %h want id%0d %h", t, ri, rd, eg, want); end
         if (t > 0) begin
            total++; if (ac - prev_ac !== S + 2) begin bad++; $display("FAIL b2b_interval got %0d want %0d", ac - prev_ac, S + 2); end
         end
         prev_ac = ac;
         m_rr = (eg + 1) % 2;
      end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic test_corrupt();
      int g, ac, lat;
      logic [20:0] ms, rd;
      logic [0:0] ri;
      logic re, pv, pb;
      bit ho;
      corrupt = 21'h000001;
      for (int t = 0; t < 4; t++) begin
         txn(2'b01, 21'h0007FF, 21'h0, 0, 1'b0, g, ac, ms, lat, rd, ri, re, ho, pv, pb);
         m_err++;
         m_rr = 1;
         total++; if (rd !== 21'h0007FE || re !== 1'b1) begin bad++; $display("FAIL cor_resp%0d got %h/%b want 0007fe/1", t, rd, re); end
         total++; if (err_count !== 16'(m_err)) begin bad++; $display("FAIL cor_cnt%0d got %0d want %0d", t, err_count, m_err); end
      end
      corrupt = '0;
   endtask

   task automatic test_backpressure();
      int g, ac, lat, eg;
      logic [20:0] ms, rd, d0, d1, want;
      logic [0:0] ri;
      logic re, pv, pb;
      bit ho;
      corrupt = '0;
      d0 = 21'($urandom);
      d1 = 21'($urandom);
      eg = exp_grant(2'b11);
      want = (eg == 0) ? d0 : d1;
      txn(2'b11, d0, d1, 10, 1'b1, g, ac, ms, lat, rd, ri, re, ho, pv, pb);
      req_valid = 2'b00;
      m_rr = (eg + 1) % 2;
      total++; if (g !== eg || rd !== want) begin bad++; $display("FAIL bp_resp got g%0d %h want g%0d %h", g, rd, eg, want); end
      total++; if (ho !== 1'b1) begin bad++; $display("FAIL bp_stable got %b want 1", ho); end
      total++; if (pv !== 1'b0 || pb !== 1'b0) begin bad++; $display("FAIL bp_release got v%b b%b want v0 b0", pv, pb); end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_single got v%b b%b want v0 b0", resp_valid, busy); end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      corrupt = '0;
      req_data = {21'h0ABCDE, 21'h055555};
      req_valid = 2'b01;
      resp_ready = 1'b1;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin tick(); n++; end
      tick();
      req_valid = 2'b00;
      tick();
      total++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL rm_settle got b%b v%b want b1 v0", busy, resp_valid); end
      rst_n = 1'b0;
      tick();
      total++; if (dp_mod !== 21'h0 || resp_data !== 21'h0 || resp_id !== 1'b0 || resp_err !== 1'b0)
         begin bad++; $display("FAIL rm_regs got %h %h %0d %b want zeros", dp_mod, resp_data, resp_id, resp_err); end
      total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || err_count !== 16'd0)
         begin bad++; $display("FAIL rm_ctrl got v%b b%b c%0d want 0 0 0", resp_valid, busy, err_count); end
      rst_n = 1'b1;
      m_rr = 0;
      m_err = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rm_noresp got %b want 0", resp_valid); end
      end
      req_valid = 2'b11;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_grant got %b want 01", req_ready); end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic test_random();
      int g, ac, lat, eg, hold;
      logic [20:0] ms, rd, d0, d1, word;
      logic [0:0] ri;
      logic re, pv, pb;
      logic [1:0] vm;
      bit ho;
      for (int t = 0; t < 30; t++) begin
         vm = 2'($urandom_range(1, 3));
         d0 = 21'($urandom);
         d1 = 21'($urandom);
         corrupt = ($urandom_range(0, 1) == 1) ? 21'($urandom_range(1, 32'h1FFFFF)) : 21'h0;
         hold = $urandom_range(0, 3);
         eg = exp_grant(vm);
         word = (eg == 0) ? d0 : d1;
         txn(vm, d0, d1, hold, 1'b0, g, ac, ms, lat, rd, ri, re, ho, pv, pb);
         if (corrupt != 21'h0 && m_err < 65535) m_err++;
         m_rr = (eg + 1) % 2;
         total++; if (g !== eg || int'(ri) !== eg) begin bad++; $display("FAIL rnd_grant%0d got %0d/%0d want %0d", t, g, ri, eg); end
         total++; if (ms !== word || lat !== S) begin bad++; $display("FAIL rnd_issue%0d got %h lat%0d want %h lat%0d", t, ms, lat, word, S); end
         total++; if (rd !== (word ^ corrupt) || re !== (corrupt != 21'h0))
            begin bad++; $display("FAIL rnd_resp%0d got %h/%b want %h/%b", t, rd, re, word ^ corrupt, corrupt != 21'h0); end
         total++; if (err_count !== 16'(m_err) || ho !== 1'b1 || pv !== 1'b0)
            begin bad++; $display("FAIL rnd_state%0d got c%0d h%b v%b want c%0d h1 v0", t, err_count, ho, pv, m_err); end
      end
      corrupt = '0;
   endtask

   task automatic test_saturation();
      int n, want;
      for (int k = 1; k <= 5; k++) begin
         s_data = {21'h0, 21'($urandom)};
         s_valid = 2'b01;
         #1;
         n = 0;
         while (s_ready == 2'b00 && n < 20) begin tick(); n++; end
         tick();
         s_valid = 2'b00;
         n = 0;
         while (!s_resp_valid && n < 20) begin tick(); n++; end
         want = (k < 3) ? k : 3;
         total++; if (s_err !== 1'b1 || s_cnt !== 2'(want))
            begin bad++; $display("FAIL sat%0d got e%b c%0d want e1 c%0d", k, s_err, s_cnt, want); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_back_to_back();
      test_corrupt();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
